// File: rtl/popcnt_pkg.sv
// Shared types and helpers for the pipelined population counter.
package popcnt_pkg;

    localparam int SAT_MAXW = 64;

    typedef struct packed {
        logic acc_en;
        logic last;
    } side_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Returns {overflow, clamped sum}; w must stay below SAT_MAXW.
    function automatic logic [SAT_MAXW:0] sat_add(
        input logic [SAT_MAXW-1:0] a,
        input logic [SAT_MAXW-1:0] b,
        input int                  w
    );
        logic [SAT_MAXW:0] s;
        logic [SAT_MAXW:0] mx;
        s  = {1'b0, a} + {1'b0, b};
        mx = ((SAT_MAXW + 1)'(1) << w) - (SAT_MAXW + 1)'(1);
        if (s > mx) return {1'b1, mx[SAT_MAXW-1:0]};
        return {1'b0, s[SAT_MAXW-1:0]};
    endfunction

endpackage

// File: rtl/popcnt_slice.sv
// Combinational bit counter for one S1 slice.
module popcnt_slice #(
    parameter int W  = 16,
    parameter int OW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_bits,
    output logic [OW-1:0] o_cnt
);

    // Written as a running sum; synthesis folds it into a compressor tree.
    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < W; i++) begin
            o_cnt = o_cnt + OW'(i_bits[i]);
        end
    end

endmodule

// File: rtl/popcnt_pipe.sv
// 3-stage population counter with burst accumulation and backpressure.
// Define POPCNT_PARITY_EN to add the out_parity port.
module popcnt_pipe
    import popcnt_pkg::*;
#(
    parameter int DEPTH     = 63,
    parameter int SLICES    = 4,
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DEPTH-1:0]     in_data,
    input  logic                 in_acc_en,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_count,
    output logic                 out_sat
`ifdef POPCNT_PARITY_EN
    ,
    output logic                 out_parity
`endif
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int SL_W  = (DEPTH + SLICES - 1) / SLICES;
    localparam int SL_CW = cnt_width(SL_W);
    localparam int PAD_W = SL_W * SLICES;

    logic                          w_adv;
    logic [PAD_W-1:0]              w_pad;
    logic [SLICES-1:0][SL_CW-1:0]  w_sl_cnt;
    logic [CNT_W-1:0]              w_s2_sum;
    logic [SAT_MAXW:0]             w_add;
    logic [ACC_WIDTH-1:0]          w_add_sum;
    logic                          w_add_ovf;
    logic                          w_unused;

    logic                          r_s1_v;
    logic [SLICES-1:0][SL_CW-1:0]  r_s1_cnt;
    side_t                         r_s1_side;
    logic                          r_s2_v;
    logic [CNT_W-1:0]              r_s2_cnt;
    side_t                         r_s2_side;
    logic [ACC_WIDTH-1:0]          r_acc;
    logic                          r_sticky;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    always_comb begin
        w_pad              = '0;
        w_pad[DEPTH-1:0]   = in_data;
    end

    for (genvar s = 0; s < SLICES; s++) begin : g_slice
        popcnt_slice #(
            .W  (SL_W),
            .OW (SL_CW)
        ) u_slice (
            .i_bits (w_pad[s*SL_W +: SL_W]),
            .o_cnt  (w_sl_cnt[s])
        );
    end

    always_comb begin
        w_s2_sum = '0;
        for (int s = 0; s < SLICES; s++) begin
            w_s2_sum = w_s2_sum + CNT_W'(r_s1_cnt[s]);
        end
    end

    assign w_add     = sat_add(SAT_MAXW'(r_acc), SAT_MAXW'(r_s2_cnt), ACC_WIDTH);
    assign w_add_sum = w_add[ACC_WIDTH-1:0];
    assign w_add_ovf = w_add[SAT_MAXW];
    assign w_unused  = ^w_add[SAT_MAXW-1:ACC_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s1_cnt  <= '0;
            r_s1_side <= '0;
            r_s2_v    <= 1'b0;
            r_s2_cnt  <= '0;
            r_s2_side <= '0;
        end else if (w_adv) begin
            r_s1_v           <= in_valid;
            r_s1_cnt         <= w_sl_cnt;
            r_s1_side.acc_en <= in_acc_en;
            r_s1_side.last   <= in_last;
            r_s2_v           <= r_s1_v;
            r_s2_cnt         <= w_s2_sum;
            r_s2_side        <= r_s1_side;
        end
    end

    // A pass-through beat leaves the accumulator alone so open bursts survive it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_count <= '0;
            out_sat   <= 1'b0;
            r_acc     <= '0;
            r_sticky  <= 1'b0;
        end else if (w_adv) begin
            out_valid <= 1'b0;
            if (r_s2_v) begin
                if (!r_s2_side.acc_en) begin
                    out_valid <= 1'b1;
                    out_count <= ACC_WIDTH'(r_s2_cnt);
                    out_sat   <= 1'b0;
                end else if (!r_s2_side.last) begin
                    r_acc    <= w_add_sum;
                    r_sticky <= r_sticky | w_add_ovf;
                end else begin
                    out_valid <= 1'b1;
                    out_count <= w_add_sum;
                    out_sat   <= r_sticky | w_add_ovf;
                    r_acc     <= '0;
                    r_sticky  <= 1'b0;
                end
            end
        end
    end

`ifdef POPCNT_PARITY_EN
    logic r_s1_par;
    logic r_s2_par;
    logic r_par_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_par   <= 1'b0;
            r_s2_par   <= 1'b0;
            r_par_acc  <= 1'b0;
            out_parity <= 1'b0;
        end else if (w_adv) begin
            r_s1_par <= ^in_data;
            r_s2_par <= r_s1_par;
            if (r_s2_v) begin
                if (!r_s2_side.acc_en) begin
                    out_parity <= r_s2_par;
                end else if (!r_s2_side.last) begin
                    r_par_acc <= r_par_acc ^ r_s2_par;
                end else begin
                    out_parity <= r_par_acc ^ r_s2_par;
                    r_par_acc  <= 1'b0;
                end
            end
        end
    end
`endif

endmodule

// File: doc/popcnt_pipe.md
Name: popcnt_pipe

Overview:
Parametrised, pipelined population counter that replaces the fixed 63-bit combinational carry-save counter. Counts set bits in a DEPTH-bit word over a 3-register pipeline and uses a valid/ready handshake with backpressure. An accumulate mode sums counts across a multi-beat burst terminated by in_last. Used in the datapath wherever weights, ones-density or match counts are needed at full clock rate.

Parameters:
DEPTH, 63, input word width in bits (>=3)
SLICES, 4, number of parallel partial counters in stage 1 (1..DEPTH)
ACC_WIDTH, 16, output/accumulator width; must be >= CNT_W
CNT_W, $clog2(DEPTH+1), derived (localparam) per-word count width; 6 at default

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  input beat valid
in_ready  out  1  pipeline can accept a beat
in_data  in  DEPTH  word to count
in_acc_en  in  1  beat belongs to an accumulate burst
in_last  in  1  final beat of burst (ignored when in_acc_en=0)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_count  out  ACC_WIDTH  count; zero-extended per-word count, or burst sum
out_sat  out  1  burst sum saturated (always 0 in per-word mode)

Behaviour:
- Reset is asynchronous and active-high. On reset, all stage valids, the accumulator, the burst-saturation flag, out_valid, out_count and out_sat clear to 0. Reset mid-burst discards the partial burst.
- Stage S1 registers SLICES partial counts. Slice width is ceil(DEPTH/SLICES); the last slice is zero-padded. Stage S2 registers the word total (CNT_W bits). Stage S3 is the output register, which includes the accumulator. in_acc_en and in_last travel with each beat.
- A beat is accepted on an edge where in_valid && in_ready.
- Latency: the result is on out_* after the 3rd edge counting the acceptance edge, with no stall. Throughput is 1 beat/cycle.
- Stall: in_ready = !out_valid || out_ready (combinational). When in_ready=0, all stages hold. out_* stay stable while out_valid && !out_ready.
- Per-word mode (acc_en=0): S3 loads zero-extended count; out_valid=1; out_sat=0. The accumulator is untouched, so a pass-through beat inside an open burst does not disturb it.
- Accumulate mode, non-last beat: acc <= sat_add(acc, cnt). The beat produces no output; out_valid for that slot is 0.
- Accumulate mode, last beat: out_count <= sat_add(acc, cnt); out_sat <= sticky_sat | overflow of this add; out_valid=1. Accumulator and sticky flag clear on the same edge.
- Single-beat burst (acc_en=1, last=1) outputs the count with out_sat=0.
- sat_add: the result is clamped to 2^ACC_WIDTH-1 and the sticky flag is set on overflow.
- The output register is overwritten only when out_valid=0 or out_ready=1.

Optional Feature:
POPCNT_PARITY_EN
- Defined: adds port out_parity (out, 1), equal to the XOR of all in_data bits. For a burst it is the XOR over all beats of the burst. It is pipelined identically to out_count and clears on reset.
- Undefined: the port and its logic are absent.

Decomposition:
- Package popcnt_pkg holds:
  - function cnt_width(depth) returning $clog2(depth+1)
  - function sat_add
  - typedef of stage-sideband struct {acc_en, last}
- Sub-module popcnt_slice is a combinational parametrised CSA/adder-tree counter of one slice (W in, $clog2(W+1) out). It is instantiated SLICES times in S1.

Test Plan:
- Per-word: in_data=all ones (DEPTH=63), acc_en=0 -> out_count=63 exactly 3 edges after acceptance; in_data=0 -> 0; in_data=63'h1 -> 1.
- Backpressure: stream 5 words (counts 1,2,3,4,5) with out_ready low for 4 cycles mid-stream -> in_ready drops; outputs are 1..5 in order, none lost or duplicated, and out_* stay stable while stalled.
- Burst: 4 beats of all-ones with acc_en=1 and last on the 4th -> a single output 252 with out_sat=0; no out_valid for beats 1-3.
- Saturation: ACC_WIDTH=8, 5 beats of all-ones -> out_count=255, out_sat=1; the next single-beat burst of count 7 -> 7, out_sat=0.
- Reset mid-burst: 2 accumulate beats, assert rst, then a burst of one beat with count 10 -> out_count=10.
- Corner geometry: DEPTH=10, SLICES=3, in_data=10'h3FF -> 10. With POPCNT_PARITY_EN, in_data=10'h007 -> out_parity=1.
